// File: rtl/alu_core.sv
// ALU core: registered arithmetic/logical results with split-operand capture.
// Handshake: inp_valid[0] qualifies opa and inp_valid[1] qualifies opb on any
// rising clk edge with ce=1. There is no back-pressure. A two-operand command
// may arrive one operand at a time; the first operand, cmd, mode and cin are
// held until the partner operand shows up or the wait times out.
// Outputs change only on the edge that completes or rejects an operation.
module alu_core #(
   parameter int WIDTH     = 8,
   parameter int CMD_WIDTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 mode,
   input  logic [CMD_WIDTH-1:0] cmd,
   input  logic [1:0]           inp_valid,
   input  logic [WIDTH-1:0]     opa,
   input  logic [WIDTH-1:0]     opb,
   input  logic                 cin,
   output logic [WIDTH:0]       res,
   output logic                 cout,
   output logic                 oflow,
   output logic                 g,
   output logic                 l,
   output logic                 e,
   output logic                 err
);

   localparam int SW    = $clog2(WIDTH);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Arithmetic command codes (mode=1)
   localparam logic [CMD_WIDTH-1:0] A_ADD     = CMD_WIDTH'(0);
   localparam logic [CMD_WIDTH-1:0] A_SUB     = CMD_WIDTH'(1);
   localparam logic [CMD_WIDTH-1:0] A_ADD_CIN = CMD_WIDTH'(2);
   localparam logic [CMD_WIDTH-1:0] A_SUB_CIN = CMD_WIDTH'(3);
   localparam logic [CMD_WIDTH-1:0] A_INC_A   = CMD_WIDTH'(4);
   localparam logic [CMD_WIDTH-1:0] A_DEC_A   = CMD_WIDTH'(5);
   localparam logic [CMD_WIDTH-1:0] A_INC_B   = CMD_WIDTH'(6);
   localparam logic [CMD_WIDTH-1:0] A_DEC_B   = CMD_WIDTH'(7);
   localparam logic [CMD_WIDTH-1:0] A_CMP     = CMD_WIDTH'(8);
   // Logical command codes (mode=0)
   localparam logic [CMD_WIDTH-1:0] L_AND     = CMD_WIDTH'(0);
   localparam logic [CMD_WIDTH-1:0] L_NAND    = CMD_WIDTH'(1);
   localparam logic [CMD_WIDTH-1:0] L_OR      = CMD_WIDTH'(2);
   localparam logic [CMD_WIDTH-1:0] L_NOR     = CMD_WIDTH'(3);
   localparam logic [CMD_WIDTH-1:0] L_XOR     = CMD_WIDTH'(4);
   localparam logic [CMD_WIDTH-1:0] L_XNOR    = CMD_WIDTH'(5);
   localparam logic [CMD_WIDTH-1:0] L_NOT_A   = CMD_WIDTH'(6);
   localparam logic [CMD_WIDTH-1:0] L_NOT_B   = CMD_WIDTH'(7);
   localparam logic [CMD_WIDTH-1:0] L_SHR1_A  = CMD_WIDTH'(8);
   localparam logic [CMD_WIDTH-1:0] L_SHL1_A  = CMD_WIDTH'(9);
   localparam logic [CMD_WIDTH-1:0] L_SHR1_B  = CMD_WIDTH'(10);
   localparam logic [CMD_WIDTH-1:0] L_SHL1_B  = CMD_WIDTH'(11);
   localparam logic [CMD_WIDTH-1:0] L_ROL     = CMD_WIDTH'(12);
   localparam logic [CMD_WIDTH-1:0] L_ROR     = CMD_WIDTH'(13);

   typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [CMD_WIDTH-1:0] cmd_q;
   logic                 mode_q, cin_q;
   logic                 latch_a, latch_b, do_exec, do_err;
   logic                 x_mode, x_cin;
   logic [CMD_WIDTH-1:0] x_cmd;
   logic [WIDTH-1:0]     x_a, x_b;
   logic [1:0]           need;
   logic [WIDTH:0]       wa, wb, wc;
   logic [2*WIDTH-1:0]   rot_l, rot_r;
   logic [WIDTH:0]       c_res;
   logic                 c_cout, c_oflow, c_g, c_l, c_e, c_err;

   // Which operand valid bits a command consumes: 11 two-operand,
   // 01 opa only, 10 opb only, 00 unlisted command.
   function automatic logic [1:0] op_need(input logic m, input logic [CMD_WIDTH-1:0] c);
      logic [1:0] n;
      n = 2'b00;
      if (m) begin
         case (c)
            A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: n = 2'b11;
            A_INC_A, A_DEC_A:                          n = 2'b01;
            A_INC_B, A_DEC_B:                          n = 2'b10;
            default:                                   n = 2'b00;
         endcase
      end else begin
         case (c)
            L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: n = 2'b11;
            L_NOT_A, L_SHR1_A, L_SHL1_A:                             n = 2'b01;
            L_NOT_B, L_SHR1_B, L_SHL1_B:                             n = 2'b10;
            default:                                                 n = 2'b00;
         endcase
      end
      return n;
   endfunction

   // Only consulted in IDLE, so it reads the live command inputs.
   assign need = op_need(mode, cmd);

   // Next-state, operand steering and capture/execute decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch_a = 1'b0;
      latch_b = 1'b0;
      do_exec = 1'b0;
      do_err  = 1'b0;
      x_mode  = mode;
      x_cmd   = cmd;
      x_cin   = cin;
      x_a     = opa;
      x_b     = opb;
      case (state_q)
         IDLE: begin
            if (inp_valid != 2'b00) begin
               if (need == 2'b11) begin
                  case (inp_valid)
                     2'b11: do_exec = 1'b1;
                     2'b01: begin latch_a = 1'b1; state_d = WAIT_B; cnt_d = '0; end
                     2'b10: begin latch_b = 1'b1; state_d = WAIT_A; cnt_d = '0; end
                     default: ;
                  endcase
               end else if (need == 2'b00) begin
                  do_exec = 1'b1;   // the execute unit rejects the unlisted code
               end else if ((inp_valid & need) != 2'b00) begin
                  do_exec = 1'b1;
               end else begin
                  do_err = 1'b1;
               end
            end
         end
         WAIT_A: begin
            x_mode = mode_q;
            x_cmd  = cmd_q;
            x_cin  = cin_q;
            x_b    = b_q;
            // Arrival wins over timeout on the final edge.
            if (inp_valid[0]) begin
               do_exec = 1'b1; state_d = IDLE; cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               do_err = 1'b1; state_d = IDLE; cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_B: begin
            x_mode = mode_q;
            x_cmd  = cmd_q;
            x_cin  = cin_q;
            x_a    = a_q;
            if (inp_valid[1]) begin
               do_exec = 1'b1; state_d = IDLE; cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               do_err = 1'b1; state_d = IDLE; cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Execute unit: result and flags for the steered operand set
   always_comb begin
      wa      = {1'b0, x_a};
      wb      = {1'b0, x_b};
      wc      = {{WIDTH{1'b0}}, x_cin};
      rot_l   = {x_a, x_a} << x_b[SW-1:0];
      rot_r   = {x_a, x_a} >> x_b[SW-1:0];
      c_res   = '0;
      c_cout  = 1'b0;
      c_oflow = 1'b0;
      c_g     = 1'b0;
      c_l     = 1'b0;
      c_e     = 1'b0;
      c_err   = 1'b0;
      if (x_mode) begin
         case (x_cmd)
            A_ADD:     begin c_res = wa + wb;      c_cout = c_res[WIDTH]; end
            A_SUB:     begin c_res = wa - wb;      c_oflow = (wa < wb); end
            A_ADD_CIN: begin c_res = wa + wb + wc; c_cout = c_res[WIDTH]; end
            A_SUB_CIN: begin c_res = wa - wb - wc; c_oflow = (wa < (wb + wc)); end
            A_INC_A:   c_res = wa + (WIDTH+1)'(1);
            A_DEC_A:   c_res = wa - (WIDTH+1)'(1);
            A_INC_B:   c_res = wb + (WIDTH+1)'(1);
            A_DEC_B:   c_res = wb - (WIDTH+1)'(1);
            A_CMP:     begin c_g = (x_a > x_b); c_l = (x_a < x_b); c_e = (x_a == x_b); end
            default:   c_err = 1'b1;
         endcase
      end else begin
         case (x_cmd)
            L_AND:    c_res = {1'b0, x_a & x_b};
            L_NAND:   c_res = {1'b0, ~(x_a & x_b)};
            L_OR:     c_res = {1'b0, x_a | x_b};
            L_NOR:    c_res = {1'b0, ~(x_a | x_b)};
            L_XOR:    c_res = {1'b0, x_a ^ x_b};
            L_XNOR:   c_res = {1'b0, ~(x_a ^ x_b)};
            L_NOT_A:  c_res = {1'b0, ~x_a};
            L_NOT_B:  c_res = {1'b0, ~x_b};
            L_SHR1_A: c_res = {1'b0, x_a >> 1};
            L_SHL1_A: c_res = {1'b0, x_a << 1};
            L_SHR1_B: c_res = {1'b0, x_b >> 1};
            L_SHL1_B: c_res = {1'b0, x_b << 1};
            L_ROL: begin
               if (|x_b[WIDTH-1:SW]) c_err = 1'b1;
               else                  c_res = {1'b0, rot_l[2*WIDTH-1:WIDTH]};
            end
            L_ROR: begin
               if (|x_b[WIDTH-1:SW]) c_err = 1'b1;
               else                  c_res = {1'b0, rot_r[WIDTH-1:0]};
            end
            default: c_err = 1'b1;
         endcase
      end
   end

   // FSM state, wait counter and captured operand/command
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= '0;
         mode_q  <= 1'b0;
         cin_q   <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_a) a_q <= opa;
         if (latch_b) b_q <= opb;
         if (latch_a || latch_b) begin
            cmd_q  <= cmd;
            mode_q <= mode;
            cin_q  <= cin;
         end
      end
   end

   // Output register: loads only on completion or rejection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res <= '0; cout <= 1'b0; oflow <= 1'b0;
         g <= 1'b0; l <= 1'b0; e <= 1'b0; err <= 1'b0;
      end else if (ce) begin
         if (do_err || (do_exec && c_err)) begin
            res <= '0; cout <= 1'b0; oflow <= 1'b0;
            g <= 1'b0; l <= 1'b0; e <= 1'b0; err <= 1'b1;
         end else if (do_exec) begin
            res <= c_res; cout <= c_cout; oflow <= c_oflow;
            g <= c_g; l <= c_l; e <= c_e; err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: table of single-edge operations, then hand-written
// sequences for split operands, timeout, clock enable and reset mid-wait.
module tb_alu_core;

   logic       clk = 1'b0;
   logic       rst, ce, mode, cin;
   logic [3:0] cmd;
   logic [1:0] inp_valid;
   logic [7:0] opa, opb;
   logic [8:0] res;
   logic       cout, oflow, g, l, e, err;

   int n_checks = 0;
   int n_fail   = 0;

   // flag vector order: {cout, oflow, g, l, e, err}
   localparam logic [5:0] F0    = 6'b000000;
   localparam logic [5:0] F_CO  = 6'b100000;
   localparam logic [5:0] F_OV  = 6'b010000;
   localparam logic [5:0] F_G   = 6'b001000;
   localparam logic [5:0] F_L   = 6'b000100;
   localparam logic [5:0] F_E   = 6'b000010;
   localparam logic [5:0] F_ERR = 6'b000001;

   typedef struct {
      string      name;
      logic       m;
      logic [3:0] c;
      logic [1:0] iv;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [8:0] r;
      logic [5:0] f;
   } vec_t;

   vec_t vecs[$];

   alu_core #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd),
      .inp_valid(inp_valid), .opa(opa), .opb(opb), .cin(cin),
      .res(res), .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e), .err(err)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input string n, input logic m, input logic [3:0] c,
                      input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [8:0] r, input logic [5:0] f);
      vec_t v;
      v.name = n; v.m = m; v.c = c; v.iv = iv; v.a = a; v.b = b;
      v.ci = ci; v.r = r; v.f = f;
      vecs.push_back(v);
   endtask

   task automatic set_in(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
      mode = m; cmd = c; inp_valid = iv; opa = a; opb = b; cin = ci;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check(input string n, input logic [8:0] er, input logic [5:0] ef);
      logic [14:0] act;
      logic [14:0] expv;
      act  = {res, cout, oflow, g, l, e, err};
      expv = {er, ef};
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got res=%h flags(co,ov,g,l,e,err)=%b, expected res=%h flags=%b",
                  n, res, {cout, oflow, g, l, e, err}, er, ef);
      end
   endtask

   // establishes a known output value (0x002) before a sequence
   task automatic known(input string n);
      set_in(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
      cyc();
      check(n, 9'h002, F0);
   endtask

   initial begin
      // reset
      rst = 1'b0;
      ce  = 1'b1;
      set_in(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
      cyc();
      cyc();
      check("reset_state", 9'h000, F0);
      rst = 1'b1;

      // single-edge operation table
      add("add_carry",     1, 4'd0,  2'b11, 8'hFF, 8'h01, 0, 9'h100, F_CO);
      add("sub_borrow",    1, 4'd1,  2'b11, 8'h05, 8'h07, 0, 9'h1FE, F_OV);
      add("sub_plain",     1, 4'd1,  2'b11, 8'h07, 8'h05, 0, 9'h002, F0);
      add("cmp_eq",        1, 4'd8,  2'b11, 8'h33, 8'h33, 0, 9'h000, F_E);
      add("cmp_gt",        1, 4'd8,  2'b11, 8'h40, 8'h20, 0, 9'h000, F_G);
      add("cmp_lt",        1, 4'd8,  2'b11, 8'h10, 8'h20, 0, 9'h000, F_L);
      add("add_cin",       1, 4'd2,  2'b11, 8'h7F, 8'h80, 1, 9'h100, F_CO);
      add("add_cin_nc",    1, 4'd2,  2'b11, 8'h10, 8'h20, 1, 9'h031, F0);
      add("sub_cin_eq",    1, 4'd3,  2'b11, 8'h10, 8'h0F, 1, 9'h000, F0);
      add("sub_cin_bor",   1, 4'd3,  2'b11, 8'h10, 8'h10, 1, 9'h1FF, F_OV);
      add("inc_a",         1, 4'd4,  2'b01, 8'hFF, 8'h00, 0, 9'h100, F0);
      add("dec_a_wrap",    1, 4'd5,  2'b01, 8'h00, 8'h00, 0, 9'h1FF, F0);
      add("inc_b_both",    1, 4'd6,  2'b11, 8'h00, 8'h41, 0, 9'h042, F0);
      add("dec_b",         1, 4'd7,  2'b10, 8'h00, 8'h00, 0, 9'h1FF, F0);
      add("dec_a_missing", 1, 4'd5,  2'b10, 8'h05, 8'h05, 0, 9'h000, F_ERR);
      add("and",           0, 4'd0,  2'b11, 8'hF0, 8'h3C, 0, 9'h030, F0);
      add("inc_b_missing", 1, 4'd6,  2'b01, 8'h05, 8'h05, 0, 9'h000, F_ERR);
      add("nand",          0, 4'd1,  2'b11, 8'hF0, 8'h3C, 0, 9'h0CF, F0);
      add("arith_cmd9",    1, 4'd9,  2'b11, 8'h01, 8'h01, 0, 9'h000, F_ERR);
      add("or",            0, 4'd2,  2'b11, 8'hF0, 8'h3C, 0, 9'h0FC, F0);
      add("nor",           0, 4'd3,  2'b11, 8'hF0, 8'h3C, 0, 9'h003, F0);
      add("xor",           0, 4'd4,  2'b11, 8'hF0, 8'h3C, 0, 9'h0CC, F0);
      add("xnor",          0, 4'd5,  2'b11, 8'hF0, 8'h3C, 0, 9'h033, F0);
      add("not_a",         0, 4'd6,  2'b01, 8'h5A, 8'h00, 0, 9'h0A5, F0);
      add("not_b",         0, 4'd7,  2'b10, 8'h00, 8'h0F, 0, 9'h0F0, F0);
      add("shr1_a",        0, 4'd8,  2'b01, 8'h81, 8'h00, 0, 9'h040, F0);
      add("shl1_a",        0, 4'd9,  2'b01, 8'h81, 8'h00, 0, 9'h002, F0);
      add("shr1_b",        0, 4'd10, 2'b10, 8'h00, 8'h03, 0, 9'h001, F0);
      add("shl1_b",        0, 4'd11, 2'b10, 8'h00, 8'h80, 0, 9'h000, F0);
      add("rol1",          0, 4'd12, 2'b11, 8'h81, 8'h01, 0, 9'h003, F0);
      add("ror_range",     0, 4'd13, 2'b11, 8'h81, 8'h80, 0, 9'h000, F_ERR);
      add("ror1",          0, 4'd13, 2'b11, 8'h81, 8'h01, 0, 9'h0C0, F0);
      add("rol_range",     0, 4'd12, 2'b11, 8'h81, 8'h09, 0, 9'h000, F_ERR);
      add("rol0",          0, 4'd12, 2'b11, 8'h81, 8'h00, 0, 9'h081, F0);
      add("logic_cmd15",   0, 4'd15, 2'b11, 8'h12, 8'h34, 0, 9'h000, F_ERR);
      add("ror7",          0, 4'd13, 2'b11, 8'h81, 8'h07, 0, 9'h003, F0);
      add("logic_cmd14",   0, 4'd14, 2'b11, 8'h12, 8'h34, 0, 9'h000, F_ERR);

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].m, vecs[i].c, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ci);
         cyc();
         check(vecs[i].name, vecs[i].r, vecs[i].f);
      end

      // idle input and ce=0 both leave outputs untouched
      known("known_idle");
      set_in(1'b1, 4'd1, 2'b00, 8'hFF, 8'h01, 1'b1);
      cyc();
      cyc();
      check("idle_hold", 9'h002, F0);
      ce = 1'b0;
      set_in(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
      cyc();
      check("ce0_hold", 9'h002, F0);
      ce = 1'b1;

      // split operands: latched cmd/opa used, new cmd and opa ignored
      known("known_split");
      set_in(1'b1, 4'd0, 2'b01, 8'h10, 8'h00, 1'b0);
      cyc();
      check("split_capture_hold", 9'h002, F0);
      inp_valid = 2'b00;
      repeat (5) cyc();
      check("split_wait_hold", 9'h002, F0);
      set_in(1'b1, 4'd4, 2'b10, 8'hEE, 8'h20, 1'b1);
      cyc();
      check("split_result", 9'h030, F0);

      // timeout: missing opa for 16 edges
      known("known_to");
      set_in(1'b1, 4'd0, 2'b10, 8'h00, 8'h04, 1'b0);
      cyc();
      inp_valid = 2'b00;
      repeat (15) cyc();
      check("to_edge15_hold", 9'h002, F0);
      cyc();
      check("to_edge16_err", 9'h000, F_ERR);

      // arrival on the 16th edge is accepted, latched mode/cmd/cin used
      known("known_to_arr");
      set_in(1'b1, 4'd0, 2'b10, 8'h00, 8'h04, 1'b0);
      cyc();
      inp_valid = 2'b00;
      repeat (15) cyc();
      set_in(1'b0, 4'd2, 2'b01, 8'h03, 8'h00, 1'b1);
      cyc();
      check("to_arrival_16", 9'h007, F0);

      // ce=0 mid-wait freezes the counter: timeout moves out by 3 edges
      known("known_ce");
      set_in(1'b1, 4'd0, 2'b10, 8'h00, 8'h04, 1'b0);
      cyc();
      inp_valid = 2'b00;
      repeat (5) cyc();
      ce = 1'b0;
      set_in(1'b1, 4'd0, 2'b01, 8'h07, 8'h00, 1'b0);
      repeat (3) cyc();
      check("ce_frozen_hold", 9'h002, F0);
      ce = 1'b1;
      inp_valid = 2'b00;
      repeat (10) cyc();
      check("ce_deferred_hold", 9'h002, F0);
      cyc();
      check("ce_deferred_err", 9'h000, F_ERR);

      // asynchronous reset while waiting for opb
      set_in(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
      cyc();
      check("pre_rst_add", 9'h100, F_CO);
      set_in(1'b1, 4'd0, 2'b01, 8'h55, 8'h00, 1'b0);
      cyc();
      inp_valid = 2'b00;
      cyc();
      cyc();
      #2 rst = 1'b0;
      #1 check("rst_async_clear", 9'h000, F0);
      cyc();
      rst = 1'b1;
      set_in(1'b1, 4'd0, 2'b10, 8'h00, 8'h01, 1'b0);
      cyc();
      check("rst_discard_latch", 9'h000, F0);
      set_in(1'b1, 4'd0, 2'b01, 8'h01, 8'h00, 1'b0);
      cyc();
      check("rst_new_split", 9'h002, F0);
      set_in(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
      cyc();
      check("rst_then_add", 9'h002, F0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
